// File: rtl/router_pkg.sv
// Shared types and header-field layout for the router egress read path.
package router_pkg;

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    PAYLOAD  = 2'd1,
    PARITY   = 2'd2
  } state_t;

  localparam int HDR_FLAG_BIT = 8;
  localparam int LEN_MSB      = 7;
  localparam int LEN_LSB      = 2;
  localparam int ADDR_MSB     = 1;
  localparam int ADDR_LSB     = 0;
  localparam int DEF_TIMEOUT  = 30;

  // One output-buffer entry: the byte plus end-of-packet and parity verdict tags.
  typedef struct packed {
    logic       last;
    logic       perr;
    logic [7:0] data;
  } buf_ent_t;

  function automatic logic [5:0] hdr_len(input logic [7:0] b);
    return b[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry output buffer between the FIFO capture stage and the destination.
module router_skid_buf
  import router_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     clr,
  input  logic     push,
  input  buf_ent_t din,
  input  logic     pop,
  output buf_ent_t head,
  output logic [1:0] occ
);

  buf_ent_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/router_egress_reader.sv
// Egress read engine: drains the port FIFO, tracks framing, flushes on stall timeout.
// Optional parity checking is built when ROUTER_PARITY_CHECK_EN is defined.
module router_egress_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int BUF_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_data,
  output logic       fifo_rd_en,
  input  logic       read_enb,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       soft_reset,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state, state_n;
  logic [5:0]  len, len_n;
  logic        inflight;
  logic [CW-1:0] stall_cnt;
  buf_ent_t    head, push_ent;
  logic [1:0]  occ;
  logic        push, frm, take_hdr, cap, hs, flag;
  logic [7:0]  b;
`ifdef ROUTER_PARITY_CHECK_EN
  logic [7:0]  acc, acc_n;
`endif

  assign vld_out    = (occ != 2'd0);
  assign data_out   = head.data;
  assign hs         = vld_out & read_enb;
  assign soft_reset = (stall_cnt == CW'(TIMEOUT));
  assign cap        = inflight & ~soft_reset;
  assign flag       = fifo_data[HDR_FLAG_BIT];
  assign b          = fifo_data[7:0];

  // Room check counts the byte already in flight so the buffer can never overflow.
  assign fifo_rd_en = ~reset & ~fifo_empty & ~soft_reset &
                      ((3'(occ) + 3'(inflight)) < (3'(BUF_DEPTH) + 3'(hs)));

  always_comb begin
    push     = 1'b0;
    frm      = 1'b0;
    take_hdr = 1'b0;
    push_ent = '0;
    push_ent.data = b;
    state_n  = state;
    len_n    = len;
`ifdef ROUTER_PARITY_CHECK_EN
    acc_n    = acc;
`endif
    if (cap) begin
      unique case (state)
        PAYLOAD: begin
          if (!flag) begin
            push  = 1'b1;
            len_n = len - 6'd1;
`ifdef ROUTER_PARITY_CHECK_EN
            acc_n = acc ^ b;
`endif
            if (len == 6'd1) state_n = PARITY;
          end else begin
            frm      = 1'b1;
            take_hdr = 1'b1;
          end
        end
        PARITY: begin
          if (!flag) begin
            push          = 1'b1;
            push_ent.last = 1'b1;
`ifdef ROUTER_PARITY_CHECK_EN
            push_ent.perr = (acc != b);
`endif
            state_n       = WAIT_HDR;
          end else begin
            frm      = 1'b1;
            take_hdr = 1'b1;
          end
        end
        default: begin
          if (flag) take_hdr = 1'b1;
          else      frm      = 1'b1;
        end
      endcase
      if (take_hdr) begin
        push    = 1'b1;
        len_n   = hdr_len(b);
`ifdef ROUTER_PARITY_CHECK_EN
        acc_n   = b;
`endif
        state_n = (hdr_len(b) == 6'd0) ? PARITY : PAYLOAD;
      end
    end
  end

  router_skid_buf u_buf (
    .clock (clock),
    .reset (reset),
    .clr   (soft_reset),
    .push  (push),
    .din   (push_ent),
    .pop   (hs & ~soft_reset),
    .head  (head),
    .occ   (occ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT_HDR;
      len        <= '0;
      inflight   <= 1'b0;
      stall_cnt  <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
      acc        <= '0;
`endif
    end else if (soft_reset) begin
      // Flush: any byte arriving this cycle is dropped with the buffer.
      state      <= WAIT_HDR;
      len        <= '0;
      inflight   <= 1'b0;
      stall_cnt  <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      inflight   <= fifo_rd_en;
      stall_cnt  <= (vld_out && !read_enb) ? stall_cnt + CW'(1) : '0;
      pkt_done   <= hs & head.last;
`ifdef ROUTER_PARITY_CHECK_EN
      acc        <= acc_n;
      parity_err <= hs & head.last & head.perr;
`else
      parity_err <= 1'b0;
`endif
      frame_err  <= frm;
    end
  end

endmodule

// File: tb/tb_router_egress_reader.sv
// Scoreboard bench for router_egress_reader: FIFO model, expected-byte queue, monitor.
module tb_router_egress_reader;

`ifdef ROUTER_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clock, reset, fifo_empty, fifo_rd_en, read_enb;
  logic [8:0] fifo_data;
  logic       vld_out, soft_reset, pkt_done, parity_err, frame_err;
  logic [7:0] data_out;

  router_egress_reader #(.TIMEOUT(30), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .read_enb(read_enb), .vld_out(vld_out),
    .data_out(data_out), .soft_reset(soft_reset), .pkt_done(pkt_done),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  typedef struct { logic [7:0] d; logic last; logic pe; } exp_t;

  logic [8:0] fq [$];
  exp_t       exp_q [$];
  int         hs_log [$];
  int errors = 0, checks = 0;
  int cyc = 0, hs_cnt = 0, fe_cnt = 0, sr_cnt = 0;
  bit pend = 0, pend_pe = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Registered-read FIFO model; flushed by soft_reset or reset.
  assign fifo_empty = (fq.size() == 0);
  always @(posedge clock) begin
    if (reset || soft_reset) begin
      fq.delete();
      fifo_data <= '0;
    end else if (fifo_rd_en && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("pkt_done", {31'b0, pkt_done}, 32'd1);
        chk("parity_err", {31'b0, parity_err}, {31'b0, pend_pe});
        pend = 0;
      end else if (pkt_done || parity_err) begin
        chk("spurious_done", {30'b0, pkt_done, parity_err}, 32'd0);
      end
      if (frame_err)  fe_cnt++;
      if (soft_reset) sr_cnt++;
      if (vld_out && read_enb) begin
        hs_cnt++;
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'b0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", {24'b0, data_out}, {24'b0, e.d});
          if (e.last) begin
            pend    = 1;
            pend_pe = e.pe;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit flag, input logic [7:0] b, input bit ex, input bit last, input bit pe);
    exp_t e;
    fq.push_back({flag, b});
    if (ex) begin
      e.d = b; e.last = last; e.pe = pe;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({name, "_drain_timeout"}, exp_q.size(), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_vld(input string name);
    int n = 0;
    while (!vld_out && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({name, "_vld_timeout"}, {31'b0, vld_out}, 32'd1);
  endtask

  initial begin
    int n, base;
    reset = 1; read_enb = 0;
    repeat (2) tick();
    chk("rst_outputs", {26'b0, vld_out, fifo_rd_en, soft_reset, pkt_done, parity_err, frame_err}, 32'd0);
    chk("rst_data_out", {24'b0, data_out}, 32'd0);
    reset = 0;
    tick();

    // Nominal packet: header 0x0D (len 3), parity 0x0D^AA^BB^CC = D0.
    hs_log.delete();
    read_enb = 1;
    send(1, 8'h0D, 1, 0, 0); send(0, 8'hAA, 1, 0, 0); send(0, 8'hBB, 1, 0, 0);
    send(0, 8'hCC, 1, 0, 0); send(0, 8'hD0, 1, 1, 0);
    drain("nominal");
    chk("nominal_count", hs_log.size(), 32'd5);
    if (hs_log.size() == 5) chk("nominal_back_to_back", hs_log[4] - hs_log[0], 32'd4);

    // Bad parity byte.
    send(1, 8'h0D, 1, 0, 0); send(0, 8'hAA, 1, 0, 0); send(0, 8'hBB, 1, 0, 0);
    send(0, 8'hCC, 1, 0, 0); send(0, 8'hD1, 1, 1, PCHK);
    drain("badpar");

    // Framing: stray payload in WAIT_HDR dropped; header mid-payload resyncs.
    base = fe_cnt;
    send(0, 8'h55, 0, 0, 0);
    send(1, 8'h0D, 1, 0, 0); send(0, 8'hAA, 1, 0, 0);
    send(1, 8'h09, 1, 0, 0); send(0, 8'h12, 1, 0, 0); send(0, 8'h34, 1, 0, 0);
    send(0, 8'h2F, 1, 1, 0);
    drain("framing");
    chk("frame_err_count", fe_cnt - base, 32'd2);

    // Near-timeout: accept on the 30th stalled cycle, no flush.
    base = sr_cnt;
    read_enb = 0;
    send(1, 8'h00, 1, 0, 0); send(0, 8'h00, 1, 1, 0);
    wait_vld("near");
    repeat (29) tick();
    chk("near_no_soft_reset", {31'b0, soft_reset}, 32'd0);
    read_enb = 1;
    drain("near");
    chk("near_sr_count", sr_cnt - base, 32'd0);

    // Timeout: stall until flush.
    base = sr_cnt;
    read_enb = 0;
    send(1, 8'h0D, 0, 0, 0); send(0, 8'hAA, 0, 0, 0); send(0, 8'hBB, 0, 0, 0);
    wait_vld("timeout");
    n = 0;
    while (!soft_reset && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 32'd30);
    chk("timeout_sr", {31'b0, soft_reset}, 32'd1);
    chk("timeout_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    tick();
    chk("timeout_vld_cleared", {30'b0, vld_out, soft_reset}, 32'd0);
    repeat (3) tick();
    chk("timeout_sr_count", sr_cnt - base, 32'd1);

    // Reset mid-packet, then a clean packet: 05 (len 1), 11, parity 05^11 = 14.
    read_enb = 1;
    base = hs_cnt;
    send(1, 8'h0D, 1, 0, 0); send(0, 8'hAA, 1, 0, 0); send(0, 8'hBB, 1, 0, 0);
    send(0, 8'hCC, 1, 0, 0); send(0, 8'hD0, 1, 1, 0);
    n = 0;
    while (hs_cnt < base + 3 && n < 50) begin
      tick();
      n++;
    end
    chk("midrst_reach", hs_cnt - base, 32'd3);
    reset = 1; read_enb = 0;
    exp_q.delete();
    tick();
    chk("midrst_outputs", {26'b0, vld_out, fifo_rd_en, soft_reset, pkt_done, parity_err, frame_err}, 32'd0);
    chk("midrst_data_out", {24'b0, data_out}, 32'd0);
    reset = 0;
    tick();
    read_enb = 1;
    send(1, 8'h05, 1, 0, 0); send(0, 8'h11, 1, 0, 0); send(0, 8'h14, 1, 1, 0);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_egress_reader.md
Name: router_egress_reader

Overview:
- Read-side engine for one router output port. It drains the 16x9 packet FIFO and presents bytes to the destination with a valid/read handshake.
- Tracks packet framing from the header length field and checks the parity byte.
- Asserts soft_reset to flush the FIFO when the destination stalls for too long.
- One instance per output port, between that port's FIFO and the destination interface.

Parameters:
- TIMEOUT, 30, consecutive stalled cycles (vld_out=1, read_enb=0) before a flush.
- BUF_DEPTH, 2, output buffer entries; fixed at 2 and needed for 1 byte/cycle throughput.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  9  FIFO read data {hdr_flag, byte}. Valid the cycle after fifo_rd_en (registered FIFO read).
- fifo_rd_en  out  1  FIFO read request.
- read_enb  in  1  destination accepts data_out this cycle.
- vld_out  out  1  data_out holds a valid byte.
- data_out  out  8  byte to destination.
- soft_reset  out  1  one-cycle flush pulse to FIFO.
- pkt_done  out  1  pulse: parity byte handshaken.
- parity_err  out  1  pulse with pkt_done on parity mismatch.
- frame_err  out  1  pulse on framing violation.

Behaviour:
- Reset: on the next edge after reset=1, all outputs go to 0. This includes data_out=8'h00, buffer empty, FSM WAIT_HDR, counters 0 and any in-flight read discarded. Reset mid-packet abandons the packet silently.
- Handshake: a byte transfers on any cycle with vld_out=1 and read_enb=1. data_out is stable while vld_out=1 and read_enb=0.
- Read issue: fifo_rd_en=1 iff fifo_empty=0, no soft_reset this cycle, and (buffer occupancy + in-flight read − handshake this cycle) < 2. At most one read is in flight.
- Latency: fifo_rd_en at cycle t, fifo_data sampled at t+1, earliest vld_out at t+2. Sustained rate is 1 byte/cycle when read_enb is held high.
- Framing FSM advances on each byte captured from the FIFO:
  - WAIT_HDR: flag=1 → capture byte, load len=byte[7:2], parity accumulator=byte. Go to PAYLOAD, or to PARITY if len=0. flag=0 → frame_err pulse, byte dropped (not presented), stay.
  - PAYLOAD: flag=0 → accumulator ^= byte, len−1; go to PARITY when len reaches 0. flag=1 → frame_err pulse, byte treated as a new header (resync); the partial packet already buffered is still delivered.
  - PARITY: flag=0 → store the expected-parity comparison with the byte and go to WAIT_HDR. flag=1 → frame_err pulse, resync as header.
- pkt_done pulses on the cycle after the parity byte's handshake. parity_err pulses in the same cycle if the accumulator differs from the parity byte.
- All bytes are presented, including header and parity.
- Timeout:
  - The stall counter increments each cycle with vld_out=1 and read_enb=0. It clears on any handshake or when vld_out=0.
  - When the counter reaches TIMEOUT, soft_reset=1 for exactly one cycle.
  - That same edge empties the buffer (vld_out=0), sets the FSM to WAIT_HDR, clears the counter, and marks any in-flight FIFO data for discard.
  - fifo_rd_en=0 during the soft_reset cycle.
- Simultaneous events: a handshake in the same cycle the counter would reach TIMEOUT wins, and no flush occurs. reset overrides everything.
- Widths: len 6 bits, stall counter sized by clog2(TIMEOUT+1), no wrap.

Optional Feature:
- Macro: ROUTER_PARITY_CHECK_EN.
- Defined: parity accumulator and compare present; parity_err behaves as specified.
- Undefined: no accumulator logic and parity_err tied to 0. pkt_done and framing are unchanged.

Decomposition:
- router_pkg holds:
  - state enum (WAIT_HDR, PAYLOAD, PARITY)
  - HDR_FLAG_BIT=8, LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0
  - default TIMEOUT=30
- Sub-module router_skid_buf: 2-entry output buffer with occupancy output, push from FIFO, pop on handshake, synchronous clear.

Test Plan:
- Nominal packet: FIFO holds {1,0x0D}, {0,0xAA}, {0,0xBB}, {0,0xCC}, {0,0xD0}, read_enb=1 → data_out 0D, AA, BB, CC, D0 on 5 consecutive cycles. pkt_done=1 one cycle after D0, parity_err=0.
- Bad parity: same packet with last byte 0xD1 → pkt_done=1 and parity_err=1 in the same cycle.
- Timeout: hold read_enb=0 with a byte presented → soft_reset=1 on the cycle the counter hits 30, vld_out=0 next cycle, fifo_rd_en=0 that cycle.
- Near-timeout: assert read_enb on stall cycle 29 → no soft_reset, counter cleared, next byte presented.
- Framing: {0,0x55} while in WAIT_HDR → frame_err=1, 0x55 never on data_out. {1,0x09} mid-payload → frame_err=1, 0x09 presented as a new header and len=2 loaded.
- Reset mid-packet: assert reset after the 2nd payload byte → all outputs 0 next cycle. The next packet {1,0x05}, {0,0x11}, {0,0x14} then delivers cleanly with parity_err=0.
